pipe_id_regbank: RTL

Parametrised decode-stage operand unit for the static pipeline CPU. It combines the register file, E/M-stage forwarding, load-use interlock, branch-equality compare and a registered ID/EXE operand latch with a ready/flush handshake. It replaces the ad-hoc regfile-plus-mux arrangement inside the decode stage. The same unit serves any register width or register count.

---
 rtl/pipe_id_regbank.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_id_regbank.sv
// pipe_id_regbank: decode-stage operand unit for the static pipeline CPU.
// Combines the register file, E/M-stage forwarding, load-use interlock,
// branch-equality compare and the registered ID/EXE operand latch.
//
// Parameters
//   WIDTH  data width of registers and operands
//   AW     register address width (2**AW registers, r0 hardwired to 0)
//   NOFWD  1 disables E/M forwarding; any E/M match then stalls until WB
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid, rs, rt,
//   use_rs, use_rt,
//   dst_in, wen_in, load_in   decoded ID instruction
//   e_* / m_*                 EXE / MEM stage destination and result info
//   w_wen, w_rn, w_data       writeback port into the register file
//   ex_ready, flush           EXE backpressure, squash of the ID instruction
//   id_ready                  ID instruction accepted this cycle
//   br_eq, fwd_a              combinational compare / forwarded operand A
//   ex_*                      registered ID/EXE operand latch
//   dbg_addr, dbg_data        debug read port (no write-through)
//
// Optional HI/LO pair enabled by defining PIPE_ID_HILO_EN:
//   hi_wen, lo_wen, hi_wdata, lo_wdata in; hi_out, lo_out out.
module pipe_id_regbank #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NOFWD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [AW-1:0]    rs,
  input  logic [AW-1:0]    rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic [AW-1:0]    dst_in,
  input  logic             wen_in,
  input  logic             load_in,
  input  logic             e_wen,
  input  logic             e_load,
  input  logic [AW-1:0]    e_rn,
  input  logic [WIDTH-1:0] e_alu,
  input  logic             m_wen,
  input  logic             m_load,
  input  logic [AW-1:0]    m_rn,
  input  logic [WIDTH-1:0] m_alu,
  input  logic [WIDTH-1:0] m_dm,
  input  logic             w_wen,
  input  logic [AW-1:0]    w_rn,
  input  logic [WIDTH-1:0] w_data,
  input  logic             ex_ready,
  input  logic             flush,
  output logic             id_ready,
  output logic             br_eq,
  output logic [WIDTH-1:0] fwd_a,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_a,
  output logic [WIDTH-1:0] ex_b,
  output logic [AW-1:0]    ex_dst,
  output logic             ex_wen,
  output logic             ex_load,
  input  logic [AW-1:0]    dbg_addr,
`ifdef PIPE_ID_HILO_EN
  input  logic             hi_wen,
  input  logic             lo_wen,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
`endif
  output logic [WIDTH-1:0] dbg_data
);

  localparam int NREG = 2 ** AW;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rf_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (w_wen && (w_rn != '0)) begin
      rf_q[w_rn] <= w_data;
    end
  end

  // Regfile reads with write-through of the WB port; r0 always reads 0.
  logic [WIDTH-1:0] rf_a, rf_b;

  always_comb begin
    rf_a = '0;
    rf_b = '0;
    if (rs != '0) begin
      rf_a = (w_wen && (w_rn == rs)) ? w_data : rf_q[rs];
    end
    if (rt != '0) begin
      rf_b = (w_wen && (w_rn == rt)) ? w_data : rf_q[rt];
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

  // ---------------------------------------------------------------------------
  // Forwarding: E (non-load) beats M, M beats the regfile.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-1:0] m_res;

  assign m_res = m_load ? m_dm : m_alu;

  always_comb begin
    opa = rf_a;
    opb = rf_b;
    if (NOFWD == 0) begin
      if (rs == '0)                             opa = '0;
      else if (e_wen && !e_load && e_rn == rs)  opa = e_alu;
      else if (m_wen && m_rn == rs)             opa = m_res;

      if (rt == '0)                             opb = '0;
      else if (e_wen && !e_load && e_rn == rt)  opb = e_alu;
      else if (m_wen && m_rn == rt)             opb = m_res;
    end
  end

  assign fwd_a = opa;
  assign br_eq = (opa == opb);

  // ---------------------------------------------------------------------------
  // Interlock
  // ---------------------------------------------------------------------------
  logic haz_load, haz_nofwd, hit_a, hit_b, hazard;

  assign haz_load = e_wen && e_load && (e_rn != '0) &&
                    ((use_rs && (e_rn == rs)) || (use_rt && (e_rn == rt)));

  // Without forwarding every in-flight producer of a used source must drain.
  assign hit_a = use_rs && (rs != '0) &&
                 ((e_wen && (e_rn == rs)) || (m_wen && (m_rn == rs)));
  assign hit_b = use_rt && (rt != '0) &&
                 ((e_wen && (e_rn == rt)) || (m_wen && (m_rn == rt)));
  assign haz_nofwd = (NOFWD != 0) && (hit_a || hit_b);

  assign hazard   = in_valid && (haz_load || haz_nofwd);
  assign id_ready = ex_ready && !hazard;

  // ---------------------------------------------------------------------------
  // ID/EXE latch
  // ---------------------------------------------------------------------------
  logic             ex_valid_q, ex_wen_q, ex_load_q;
  logic [WIDTH-1:0] ex_a_q, ex_b_q;
  logic [AW-1:0]    ex_dst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_dst_q   <= '0;
      ex_wen_q   <= 1'b0;
      ex_load_q  <= 1'b0;
    end else if (ex_ready) begin
      if (flush || hazard || !in_valid) begin
        ex_valid_q <= 1'b0;
        ex_a_q     <= '0;
        ex_b_q     <= '0;
        ex_dst_q   <= '0;
        ex_wen_q   <= 1'b0;
        ex_load_q  <= 1'b0;
      end else begin
        ex_valid_q <= 1'b1;
        ex_a_q     <= opa;
        ex_b_q     <= opb;
        ex_dst_q   <= dst_in;
        ex_wen_q   <= wen_in;
        ex_load_q  <= load_in;
      end
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_a     = ex_a_q;
  assign ex_b     = ex_b_q;
  assign ex_dst   = ex_dst_q;
  assign ex_wen   = ex_wen_q;
  assign ex_load  = ex_load_q;

`ifdef PIPE_ID_HILO_EN
  // ---------------------------------------------------------------------------
  // HI/LO pair with write-through reads
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] hi_q, lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_wen) hi_q <= hi_wdata;
      if (lo_wen) lo_q <= lo_wdata;
    end
  end

  assign hi_out = hi_wen ? hi_wdata : hi_q;
  assign lo_out = lo_wen ? lo_wdata : lo_q;
`endif

endmodule
